// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed driver for a NUM_DIGITS-digit 7-segment hex display.
//   A prescaler holds each digit lit for PRESCALE clk cycles. The scan then
//   steps to the next digit and wraps from the last digit back to digit 0.
//   Optional leading-zero blanking is supported. All outputs are registered.
//
// Parameters
//   NUM_DIGITS  number of digits (1..8)
//   PRESCALE    clk cycles each digit is lit (1..2^20)
//   ACTIVE_LOW  1: seg/dp/an are low-true, 0: high-true
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   load        capture value/dp_in/blank_lz into the display registers
//   value       packed hex digits, digit k = value[4k+3:4k], digit 0 rightmost
//   dp_in       decimal-point request per digit
//   blank_lz    leading-zero blanking enable (captured with load)
//   seg         segment drive, seg[0]=a .. seg[6]=g
//   dp          decimal-point drive
//   an          digit enables, one-hot when active
//   frame_done  one-cycle high-true pulse when the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Internal levels are computed low-true; these masks flip them for high-true
  // displays on the way into the output registers.
  localparam logic [6:0]            SEG_POL = ACTIVE_LOW ? 7'b0000000 : 7'b1111111;
  localparam logic                  DP_POL  = ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic [NUM_DIGITS-1:0] AN_POL  = ACTIVE_LOW ? {NUM_DIGITS{1'b0}}
                                                         : {NUM_DIGITS{1'b1}};
  localparam logic [6:0]            SEG_BLANK = 7'b1111111;

  // Low-true hex decode, bit order g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [PW-1:0]           presc_r;
  logic [IW-1:0]           idx_r;
  logic [4*NUM_DIGITS-1:0] val_r;
  logic [NUM_DIGITS-1:0]   dp_r;
  logic                    blz_r;

  logic                    adv_s;
  logic                    last_s;
  logic [3:0]              digit_s;
  logic [4*NUM_DIGITS-1:0] upper_s;
  logic                    blank_s;
  logic [NUM_DIGITS-1:0]   one_s;
  logic [6:0]              seg_lvl_s;
  logic                    dp_lvl_s;

  // Scan decode: advance event, current digit, blanking and low-true levels.
  always_comb begin
    adv_s   = (presc_r == PRESC_LAST);
    last_s  = (idx_r == IDX_LAST);
    digit_s = val_r[{idx_r, 2'b00} +: 4];
    // The current digit is a leading zero when it and every digit above it
    // are zero. Digit 0 is never blanked.
    upper_s = val_r >> {idx_r, 2'b00};
    blank_s = blz_r && (idx_r != {IW{1'b0}}) && (upper_s == {(4*NUM_DIGITS){1'b0}});
    one_s   = {NUM_DIGITS{1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      one_s[k] = (idx_r == IW'(k));
    end
    if (blank_s) begin
      seg_lvl_s = SEG_BLANK;
      dp_lvl_s  = 1'b1;
    end else begin
      seg_lvl_s = hex_to_seg(digit_s);
      dp_lvl_s  = ~dp_r[idx_r];
    end
  end

  // Prescaler, digit index, display registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r    <= {PW{1'b0}};
      idx_r      <= {IW{1'b0}};
      val_r      <= {(4*NUM_DIGITS){1'b0}};
      dp_r       <= {NUM_DIGITS{1'b0}};
      blz_r      <= 1'b0;
      seg        <= SEG_BLANK ^ SEG_POL;
      dp         <= 1'b1 ^ DP_POL;
      an         <= {NUM_DIGITS{1'b1}} ^ AN_POL;
      frame_done <= 1'b0;
    end else begin
      if (adv_s) begin
        presc_r <= {PW{1'b0}};
        if (last_s) begin
          idx_r <= {IW{1'b0}};
        end else begin
          idx_r <= idx_r + IW'(1'b1);
        end
      end else begin
        presc_r <= presc_r + PW'(1'b1);
        idx_r   <= idx_r;
      end
      frame_done <= adv_s && last_s;
      if (load) begin
        val_r <= value;
        dp_r  <= dp_in;
        blz_r <= blank_lz;
      end else begin
        val_r <= val_r;
        dp_r  <= dp_r;
        blz_r <= blz_r;
      end
      // Outputs use the pre-edge index and display registers.
      seg <= seg_lvl_s ^ SEG_POL;
      dp  <= dp_lvl_s ^ DP_POL;
      an  <= (~one_s) ^ AN_POL;
    end
  end

endmodule
